// File: rtl/nfa_pkg.sv
// Shared types and default constants for the NFA match reporter.
package nfa_pkg;

   localparam int MATCH_LAT_DEF  = 3;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int OFF_W_DEF      = 16;
   localparam int ID_W_DEF       = 8;

   // One queued report at the default widths: which packet, which byte.
   typedef struct packed {
      logic [ID_W_DEF-1:0]  id;
      logic [OFF_W_DEF-1:0] offset;
   } report_t;

   // Per-packet reporting state, tracked on the delayed byte stream.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_PKT   = 2'd1,
      ST_REPORTED = 2'd2
   } state_t;

endpackage

// File: rtl/nfa_rpt_fifo.sv
// Synchronous first-word-fall-through FIFO holding match reports.
// The head entry is presented on dout whenever the FIFO is not empty;
// dout reads as zero while empty. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module nfa_rpt_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/nfa_match_reporter.sv
// Tags bytes with packet id and offset, delays the tags to line up with the
// NFA match output, and queues the first match of each packet as a report.
// Optional feature macro NFA_RPT_COUNT_EN adds a saturating 32-bit
// match_count output counting every match seen on a valid delayed byte.
module nfa_match_reporter
   import nfa_pkg::*;
#(
   parameter int MATCH_LAT  = MATCH_LAT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int OFF_W      = OFF_W_DEF,
   parameter int ID_W       = ID_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sop,
   input  logic             eop,
   input  logic             match,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [ID_W-1:0]  rpt_id,
   output logic [OFF_W-1:0] rpt_offset,
`ifdef NFA_RPT_COUNT_EN
   output logic [31:0]      match_count,
`endif
   output logic             rpt_ovf,
   input  logic             ovf_clr
);

   localparam int RPT_W = ID_W + OFF_W;

   logic [OFF_W-1:0]     off_q;
   logic [OFF_W-1:0]     cur_off;
   logic [ID_W-1:0]      pkt_id_q;
   logic [ID_W-1:0]      next_id_q;
   logic [ID_W-1:0]      cur_id;
   logic [MATCH_LAT-1:0] p_en;
   logic [MATCH_LAT-1:0] p_sop;
   logic [MATCH_LAT-1:0] p_eop;
   logic [ID_W-1:0]      p_id  [MATCH_LAT];
   logic [OFF_W-1:0]     p_off [MATCH_LAT];
   logic                 d_en;
   logic                 d_sop;
   logic                 d_eop;
   state_t               state_q;
   state_t               state_d;
   logic                 push_req;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [RPT_W-1:0]     fifo_dout;
   logic                 ovf_evt;

   // Tag the incoming byte: sop restarts the offset and claims the next id.
   always_comb begin
      cur_off = off_q;
      cur_id  = pkt_id_q;
      if (en) begin
         if (sop) begin
            cur_off = '0;
            cur_id  = next_id_q;
         end else if (off_q != '1) begin
            cur_off = off_q + 1'b1;
         end
      end
   end

   // Hold the current packet's offset and id, and advance the id allocator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         off_q     <= '0;
         pkt_id_q  <= '0;
         next_id_q <= '0;
      end else if (en) begin
         off_q    <= cur_off;
         pkt_id_q <= cur_id;
         if (sop) next_id_q <= next_id_q + 1'b1;
      end
   end

   // Delay the byte tags so they arrive together with the NFA match result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_en  <= '0;
         p_sop <= '0;
         p_eop <= '0;
         for (int i = 0; i < MATCH_LAT; i++) begin
            p_id[i]  <= '0;
            p_off[i] <= '0;
         end
      end else begin
         p_en[0]  <= en;
         p_sop[0] <= en && sop;
         p_eop[0] <= en && eop;
         p_id[0]  <= cur_id;
         p_off[0] <= cur_off;
         for (int i = 1; i < MATCH_LAT; i++) begin
            p_en[i]  <= p_en[i-1];
            p_sop[i] <= p_sop[i-1];
            p_eop[i] <= p_eop[i-1];
            p_id[i]  <= p_id[i-1];
            p_off[i] <= p_off[i-1];
         end
      end
   end

   assign d_en  = p_en[MATCH_LAT-1];
   assign d_sop = p_sop[MATCH_LAT-1];
   assign d_eop = p_eop[MATCH_LAT-1];

   // Reporting state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and push decision; a sop byte always starts a fresh packet.
   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      if (d_en) begin
         if (d_sop) begin
            if (match) begin
               push_req = 1'b1;
               state_d  = ST_REPORTED;
            end else begin
               state_d  = ST_IN_PKT;
            end
            if (d_eop) state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IN_PKT: begin
                  if (match) begin
                     push_req = 1'b1;
                     state_d  = ST_REPORTED;
                  end
                  if (d_eop) state_d = ST_IDLE;
               end
               ST_REPORTED: begin
                  if (d_eop) state_d = ST_IDLE;
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   assign pop     = rpt_valid && rpt_ready;
   assign ovf_evt = push_req && fifo_full && !pop;

   nfa_rpt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (RPT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .din   ({p_id[MATCH_LAT-1], p_off[MATCH_LAT-1]}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rpt_valid  = !fifo_empty;
   assign rpt_id     = fifo_dout[RPT_W-1:OFF_W];
   assign rpt_offset = fifo_dout[OFF_W-1:0];

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        rpt_ovf <= 1'b0;
      else if (ovf_evt) rpt_ovf <= 1'b1;
      else if (ovf_clr) rpt_ovf <= 1'b0;
   end

`ifdef NFA_RPT_COUNT_EN
   // Count every match on a valid delayed byte, including ignored repeats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 match_count <= '0;
      else if (d_en && match && match_count != '1) match_count <= match_count + 1'b1;
   end
`endif

endmodule
